// File: rtl/time_set_ctrl.sv
// time_set_ctrl: sequences the clock counter chain between normal running and
// a three-field set mode (hours, minutes, seconds). Converts debounced mode and
// select button levels into field selection, single-step / auto-repeat advance
// pulses and a seconds clear, and gates the 1 Hz tick into the seconds counter.
// Every output is driven straight from a flip-flop.
module time_set_ctrl #(
   parameter int HOLD_TICKS    = 8,
   parameter int REPEAT_TICKS  = 2,
   parameter int TIMEOUT_TICKS = 30
) (
   input  logic       clkmain,
   input  logic       clear_n,
   input  logic       tick_1hz,
   input  logic       tick_fast,
   input  logic       mode_btn,
   input  logic       slt_btn,
   output logic [1:0] state,
   output logic       set_time,
   output logic [2:0] field_sel,
   output logic       run_en,
   output logic       adv_hr,
   output logic       adv_min,
   output logic       sec_clr,
   output logic       blink
);

   localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
   localparam int RP_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int RP_W   = $clog2(RP_MAX + 1);

   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
   localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_TICKS - 1);
   localparam logic [RP_W-1:0] RPT_LAST  = RP_W'(REPEAT_TICKS - 1);

   typedef enum logic [1:0] {
      ST_RUN = 2'b00,
      ST_HR  = 2'b01,
      ST_MIN = 2'b10,
      ST_SEC = 2'b11
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [2:0]        w_field_sel_nxt;

   logic              r_mode_q;
   logic              r_slt_q;
   logic [TO_W-1:0]   r_to_cnt;
   logic [RP_W-1:0]   r_rep_cnt;
   logic              r_rep_arm;
   logic              r_rep_phase;

   logic              r_set_time;
   logic [2:0]        r_field_sel;
   logic              r_run_en;
   logic              r_adv_hr;
   logic              r_adv_min;
   logic              r_sec_clr;
   logic              r_blink;

   logic              w_mode_edge;
   logic              w_slt_edge;
   logic              w_in_set;
   logic              w_adj_state;
   logic              w_to_hit;
   logic              w_rep_tick;
   logic              w_rep_last;
   logic              w_rep_fire;
   logic              w_step;
   logic              w_adv;

   // Rising-edge detection on the button levels, and the decisions derived from them.
   // A mode edge always wins: it discards a simultaneous select edge and any repeat.
   assign w_mode_edge = mode_btn & ~r_mode_q;
   assign w_slt_edge  = slt_btn & ~r_slt_q;
   assign w_in_set    = (r_state != ST_RUN);
   assign w_adj_state = (r_state == ST_HR) | (r_state == ST_MIN);
   // Timeout fires on the tick that would make the idle count reach its limit,
   // unless a button edge in the same cycle restarts the idle period.
   assign w_to_hit    = w_in_set & tick_1hz & ~w_mode_edge & ~w_slt_edge
                        & (r_to_cnt == TO_LAST);
   assign w_rep_tick  = w_adj_state & r_rep_arm & slt_btn & tick_fast
                        & ~w_slt_edge & ~w_mode_edge & ~w_to_hit;
   assign w_rep_last  = r_rep_phase ? (r_rep_cnt == RPT_LAST) : (r_rep_cnt == HOLD_LAST);
   assign w_rep_fire  = w_rep_tick & w_rep_last;
   assign w_step      = w_adj_state & w_slt_edge & ~w_mode_edge;
   assign w_adv       = w_step | w_rep_fire;

   // Button level history; reset high so a button held through reset gives no edge.
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_mode_q <= 1'b1;
         r_slt_q  <= 1'b1;
      end else begin
         r_mode_q <= mode_btn;
         r_slt_q  <= slt_btn;
      end
   end

   // Next-state logic: mode edge cycles the fields, timeout drops back to RUN.
   always_comb begin
      w_state_nxt     = r_state;
      w_field_sel_nxt = 3'b000;
      if (w_mode_edge) begin
         case (r_state)
            ST_RUN:  w_state_nxt = ST_HR;
            ST_HR:   w_state_nxt = ST_MIN;
            ST_MIN:  w_state_nxt = ST_SEC;
            default: w_state_nxt = ST_RUN;
         endcase
      end else if (w_to_hit) begin
         w_state_nxt = ST_RUN;
      end
      case (w_state_nxt)
         ST_HR:   w_field_sel_nxt = 3'b100;
         ST_MIN:  w_field_sel_nxt = 3'b010;
         ST_SEC:  w_field_sel_nxt = 3'b001;
         default: w_field_sel_nxt = 3'b000;
      endcase
   end

   // State register with its registered decodes (set_time, field_sel).
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_state     <= ST_RUN;
         r_set_time  <= 1'b0;
         r_field_sel <= 3'b000;
      end else begin
         r_state     <= w_state_nxt;
         r_set_time  <= (w_state_nxt != ST_RUN);
         r_field_sel <= w_field_sel_nxt;
      end
   end

   // Idle timeout: counts 1 Hz ticks in set mode, restarted by any button edge.
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_to_cnt <= '0;
      end else if (w_mode_edge | w_slt_edge | ~w_in_set | w_to_hit) begin
         r_to_cnt <= '0;
      end else if (tick_1hz) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // Auto-repeat: armed by an accepted select press, first counts the hold
   // delay (phase 0), then the repeat interval over and over (phase 1).
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_rep_arm   <= 1'b0;
         r_rep_phase <= 1'b0;
         r_rep_cnt   <= '0;
      end else if (w_mode_edge | ~w_adj_state | w_to_hit | ~slt_btn) begin
         r_rep_arm   <= 1'b0;
         r_rep_phase <= 1'b0;
         r_rep_cnt   <= '0;
      end else if (w_slt_edge) begin
         r_rep_arm   <= 1'b1;
         r_rep_phase <= 1'b0;
         r_rep_cnt   <= '0;
      end else if (w_rep_tick) begin
         if (w_rep_last) begin
            r_rep_phase <= 1'b1;
            r_rep_cnt   <= '0;
         end else begin
            r_rep_cnt   <= r_rep_cnt + RP_W'(1);
         end
      end
   end

   // One-cycle output pulses: seconds enable, field advances and seconds clear.
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_run_en  <= 1'b0;
         r_adv_hr  <= 1'b0;
         r_adv_min <= 1'b0;
         r_sec_clr <= 1'b0;
      end else begin
         r_run_en  <= tick_1hz & (r_state == ST_RUN);
         r_adv_hr  <= w_adv & (r_state == ST_HR);
         r_adv_min <= w_adv & (r_state == ST_MIN);
         r_sec_clr <= w_slt_edge & ~w_mode_edge & (r_state == ST_SEC);
      end
   end

   // Display blink: toggles on the fast tick while setting, off in RUN.
   always_ff @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) begin
         r_blink <= 1'b0;
      end else if (w_state_nxt == ST_RUN) begin
         r_blink <= 1'b0;
      end else if (tick_fast) begin
         r_blink <= ~r_blink;
      end
   end

   assign state     = r_state;
   assign set_time  = r_set_time;
   assign field_sel = r_field_sel;
   assign run_en    = r_run_en;
   assign adv_hr    = r_adv_hr;
   assign adv_min   = r_adv_min;
   assign sec_clr   = r_sec_clr;
   assign blink     = r_blink;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: a vector table, hand-written corner sequences and a
// random run, all checked each cycle against a field-level behavioural model.
module tb_time_set_ctrl;

   localparam int HOLD    = 8;
   localparam int REPEAT  = 2;
   localparam int TIMEOUT = 30;

   logic       clkmain = 1'b0;
   logic       clear_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_fast = 1'b0;
   logic       mode_btn = 1'b0;
   logic       slt_btn = 1'b0;
   logic [1:0] state;
   logic       set_time;
   logic [2:0] field_sel;
   logic       run_en;
   logic       adv_hr;
   logic       adv_min;
   logic       sec_clr;
   logic       blink;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ahr, n_amin, n_clr;

   time_set_ctrl #(
      .HOLD_TICKS(HOLD), .REPEAT_TICKS(REPEAT), .TIMEOUT_TICKS(TIMEOUT)
   ) dut (
      .clkmain(clkmain), .clear_n(clear_n), .tick_1hz(tick_1hz), .tick_fast(tick_fast),
      .mode_btn(mode_btn), .slt_btn(slt_btn), .state(state), .set_time(set_time),
      .field_sel(field_sel), .run_en(run_en), .adv_hr(adv_hr), .adv_min(adv_min),
      .sec_clr(sec_clr), .blink(blink)
   );

   always #5 clkmain = ~clkmain;

   // ---------------- behavioural model ----------------
   // field: 0 RUN, 1 hours, 2 minutes, 3 seconds. idle counts 1 Hz ticks since
   // the last button edge; k counts fast ticks since the accepted select press.
   typedef struct {
      int field;
      int idle;
      int k;
      bit armed;
      bit pm, ps;
      bit run, ahr, amin, clr, blk;
   } ms_t;

   function automatic ms_t mreset();
      ms_t r;
      r.field = 0; r.idle = 0; r.k = 0; r.armed = 0;
      r.pm = 1; r.ps = 1;
      r.run = 0; r.ahr = 0; r.amin = 0; r.clr = 0; r.blk = 0;
      return r;
   endfunction

   function automatic ms_t mnext(ms_t c, bit m, bit s, bit t1, bit tf);
      ms_t n;
      bit  me, se, to, adv;
      n   = c;
      adv = 0;
      me  = m && !c.pm;
      se  = s && !c.ps;
      n.run = t1 && (c.field == 0);
      n.ahr = 0; n.amin = 0; n.clr = 0;
      to  = (c.field != 0) && !me && !se && t1 && (c.idle + 1 == TIMEOUT);
      if (me) begin
         n.field = (c.field + 1) % 4; n.idle = 0; n.armed = 0; n.k = 0;
      end else if (to) begin
         n.field = 0; n.idle = 0; n.armed = 0; n.k = 0;
      end else begin
         if (c.field == 0 || se) n.idle = 0;
         else if (t1)            n.idle = c.idle + 1;
         if (c.field == 1 || c.field == 2) begin
            if (se) begin
               n.armed = 1; n.k = 0; adv = 1;
            end else if (!s) begin
               n.armed = 0; n.k = 0;
            end else if (tf && c.armed) begin
               n.k = c.k + 1;
               adv = (n.k >= HOLD) && ((n.k - HOLD) % REPEAT == 0);
            end
            n.ahr  = adv && (c.field == 1);
            n.amin = adv && (c.field == 2);
         end else begin
            n.armed = 0; n.k = 0;
         end
         if (c.field == 3 && se) n.clr = 1;
      end
      n.blk = (n.field == 0) ? 1'b0 : (tf ? !c.blk : c.blk);
      n.pm = m; n.ps = s;
      return n;
   endfunction

   ms_t ms = mreset();

   always @(posedge clkmain or negedge clear_n) begin
      if (!clear_n) ms <= mreset();
      else          ms <= mnext(ms, mode_btn, slt_btn, tick_1hz, tick_fast);
   end

   function automatic logic [2:0] fsel(int f);
      case (f)
         1:       return 3'b100;
         2:       return 3'b010;
         3:       return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic model_cmp();
      logic [11:0] got, exp;
      got = {state, set_time, field_sel, run_en, adv_hr, adv_min, sec_clr, blink};
      exp = {ms.field[1:0], (ms.field != 0), fsel(ms.field), ms.run, ms.ahr, ms.amin,
             ms.clr, ms.blk};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL model {st,set,sel,run,ahr,amin,clr,blk}: got %b, expected %b (t=%0t)",
                  got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, then sample outputs on the falling edge.
   task automatic step(input bit m, input bit s, input bit t1, input bit tf);
      mode_btn = m; slt_btn = s; tick_1hz = t1; tick_fast = tf;
      @(negedge clkmain);
      if (adv_hr)  n_ahr++;
      if (adv_min) n_amin++;
      if (sec_clr) n_clr++;
      model_cmp();
   endtask

   typedef struct {
      bit m, s, t1, tf;
      int st;
      bit run, ahr, amin, clr;
   } vec_t;

   vec_t vt[13];
   int   mr, sr;
   bit   rm, rs;

   initial begin
      // Vector table: starts from RUN with both buttons released.
      vt[0]  = '{0,0,1,0, 0, 1,0,0,0};
      vt[1]  = '{1,0,0,0, 1, 0,0,0,0};
      vt[2]  = '{1,1,0,0, 1, 0,1,0,0};
      vt[3]  = '{0,0,1,0, 1, 0,0,0,0};
      vt[4]  = '{1,1,0,0, 2, 0,0,0,0};
      vt[5]  = '{0,0,0,0, 2, 0,0,0,0};
      vt[6]  = '{0,1,0,0, 2, 0,0,1,0};
      vt[7]  = '{0,0,0,0, 2, 0,0,0,0};
      vt[8]  = '{1,0,0,0, 3, 0,0,0,0};
      vt[9]  = '{0,1,0,0, 3, 0,0,0,1};
      vt[10] = '{0,1,0,1, 3, 0,0,0,0};
      vt[11] = '{1,0,0,0, 0, 0,0,0,0};
      vt[12] = '{0,0,1,0, 0, 1,0,0,0};

      // Reset with mode held, release, keep holding.
      mode_btn = 1'b1;
      step(1,0,0,0); step(1,0,0,0);
      chk("reset_state", state, 0);
      chk("reset_pulses", {run_en, adv_hr, adv_min, sec_clr, blink, set_time}, 0);
      clear_n = 1'b1;
      n_ahr = 0; n_amin = 0; n_clr = 0;
      for (int i = 0; i < 10; i++) step(1,0,0,0);
      chk("held_mode_state", state, 0);
      chk("held_mode_set_time", set_time, 0);
      chk("held_mode_pulses", n_ahr + n_amin + n_clr, 0);
      step(0,0,0,0);
      step(0,0,1,0);
      chk("run_en_after_tick", run_en, 1);
      step(0,0,0,0);
      chk("run_en_one_cycle", run_en, 0);

      // Table-driven vectors.
      for (int i = 0; i < 13; i++) begin
         step(vt[i].m, vt[i].s, vt[i].t1, vt[i].tf);
         chk($sformatf("vec%0d_state", i), state, vt[i].st);
         chk($sformatf("vec%0d_pulses", i), {run_en, adv_hr, adv_min, sec_clr},
             {vt[i].run, vt[i].ahr, vt[i].amin, vt[i].clr});
      end

      // Four mode presses, tick_1hz frozen in SET states.
      step(0,0,0,0);
      for (int i = 0; i < 4; i++) begin
         step(1,0,0,0);
         chk($sformatf("mode%0d_state", i), state, (i + 1) % 4);
         chk($sformatf("mode%0d_sel", i), field_sel, fsel((i + 1) % 4));
         if (i < 3) begin
            for (int j = 0; j < 2; j++) begin
               step(0,0,1,0);
               chk("run_en_frozen", run_en, 0);
            end
         end else begin
            step(0,0,0,0);
         end
      end

      // Auto-repeat in SET_MIN.
      step(1,0,0,0); step(0,0,0,0); step(1,0,0,0); step(0,0,0,0);
      chk("in_set_min", state, 2);
      n_ahr = 0; n_amin = 0; n_clr = 0;
      step(0,1,0,0);
      for (int i = 0; i < 14; i++) begin
         step(0,1,0,1); step(0,1,0,0);
      end
      step(0,0,0,0);
      chk("repeat_adv_min_count", n_amin, 5);
      chk("repeat_other_pulses", n_ahr + n_clr, 0);

      // SET_SEC clear, then simultaneous mode+slt edges in SET_HR.
      step(1,0,0,0); step(0,0,0,0);
      n_clr = 0;
      step(0,1,0,0); step(0,0,0,0);
      chk("sec_clr_count", n_clr, 1);
      chk("sec_state", state, 3);
      step(1,0,0,0); step(0,0,0,0); step(1,0,0,0); step(0,0,0,0);
      chk("back_in_hr", state, 1);
      n_ahr = 0;
      step(1,1,0,0);
      chk("both_edges_state", state, 2);
      chk("both_edges_no_adv", n_ahr, 0);
      step(0,0,0,0);
      step(1,0,0,0); step(0,0,0,0); step(1,0,0,0); step(0,0,0,0);
      chk("run_again", state, 0);

      // Timeout from SET_HR.
      step(1,0,0,0); step(0,0,0,0);
      for (int i = 1; i <= 30; i++) begin
         step(0,0,1,0);
         if (i == 29) chk("timeout_tick29", state, 1);
      end
      chk("timeout_tick30", state, 0);
      step(1,0,0,0); step(0,0,0,0);
      for (int i = 1; i <= 28; i++) step(0,0,1,0);
      step(0,1,1,0);
      step(0,0,0,0);
      chk("slt_on_tick29_stay", state, 1);
      for (int i = 1; i <= 30; i++) begin
         step(0,0,1,0);
         if (i == 29) chk("timeout_restart_29", state, 1);
      end
      chk("timeout_restart_30", state, 0);

      // Reset in the middle of auto-repeat in SET_MIN.
      step(1,0,0,0); step(0,0,0,0); step(1,0,0,0); step(0,0,0,0);
      step(0,1,0,0);
      for (int i = 0; i < 10; i++) begin
         step(0,1,0,0); step(0,1,0,1);
      end
      chk("pre_reset_adv_min", adv_min, 1);
      #2 clear_n = 1'b0;
      #1;
      chk("async_reset_state", state, 0);
      chk("async_reset_outs", {set_time, field_sel, run_en, adv_hr, adv_min, sec_clr, blink}, 0);
      step(0,1,0,1);
      clear_n = 1'b1;
      n_amin = 0;
      for (int i = 0; i < 12; i++) begin
         step(0,1,0,1); step(0,1,0,0);
      end
      chk("post_reset_no_adv", n_amin, 0);

      // Randomised run with varying button activity.
      rm = 0; rs = 1;
      for (int i = 0; i < 4000; i++) begin
         case (i / 1000)
            0:       begin mr = 30;  sr = 10;  end
            1:       begin mr = 200; sr = 15;  end
            2:       begin mr = 600; sr = 600; end
            default: begin mr = 20;  sr = 5;   end
         endcase
         if ($urandom_range(0, mr) == 0) rm = ~rm;
         if ($urandom_range(0, sr) == 0) rs = ~rs;
         step(rm, rs, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
